pixel_streamer: RTL and testbench

Raster-scan image source that feeds the 3x3 window pixel buffer. On start it reads an image of size_x by size_y pixels from the single-port pixel RAM, sequentially from address 0, and emits the pixels as a valid/ready stream. It supports downstream backpressure. After the last image pixel it appends size_x+1 zero "flush" pixels, so the window centre reaches the last image pixel.

---
 rtl/pixel_streamer.sv | 137 +++++++++++++
 tb/tb_pixel_streamer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_streamer.sv
// Raster-scan pixel source: reads size_x*size_y pixels from the pixel RAM in
// address order and streams them, followed by size_x+1 zero flush pixels.
module pixel_streamer #(
  parameter int PIX_WIDTH  = 8,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [11:0]           size_x,
  input  logic [11:0]           size_y,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_ren,
  input  logic [PIX_WIDTH-1:0]  ram_data_out,
  output logic [PIX_WIDTH-1:0]  pixel_out,
  output logic                  pixel_out_valid,
  input  logic                  pixel_out_ready,
  output logic                  pixel_flush,
  output logic                  frame_end,
  output logic                  busy,
  output logic                  err
);

  localparam int EW = PIX_WIDTH + 2;
  localparam logic [23:0] MAX_PIXELS = 24'(2 ** ADDR_WIDTH);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DRAIN} state_t;
  state_t state, state_next;

  logic [23:0]   frame_pixels, pixels_r;
  logic [11:0]   size_x_r, flush_cnt;
  logic          size_ok, slot_free, inflight, flush_push, pop;
  logic          last_read, last_flush;
  logic [EW-1:0] fifo0, fifo1, fifo0_next, fifo1_next;
  logic [1:0]    count, count_next;

  assign frame_pixels = {12'd0, size_x} * {12'd0, size_y};
  assign size_ok      = (size_x != 12'd0) && (size_y != 12'd0) && (frame_pixels <= MAX_PIXELS);
  // Occupancy plus the read in flight, deliberately ignoring this cycle's pop.
  assign slot_free    = ({1'b0, count} + {2'b00, inflight}) < 3'd2;
  assign pop          = pixel_out_valid && pixel_out_ready;
  assign last_read    = {{(24-ADDR_WIDTH){1'b0}}, ram_address} == (pixels_r - 24'd1);
  assign last_flush   = flush_cnt == size_x_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start && size_ok)           state_next = READ;
      READ:  if (ram_ren && last_read)       state_next = FLUSH;
      FLUSH: if (flush_push && last_flush)   state_next = DRAIN;
      DRAIN: if (pop && fifo0[0])            state_next = IDLE;
      default:                               state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_ren    = 1'b0;
    flush_push = 1'b0;
    busy       = 1'b0;
    case (state)
      READ:    begin ram_ren    = slot_free; busy = 1'b1; end
      FLUSH:   begin flush_push = slot_free; busy = 1'b1; end
      DRAIN:   busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_address <= '0;
      inflight    <= 1'b0;
      size_x_r    <= '0;
      pixels_r    <= '0;
      flush_cnt   <= '0;
      err         <= 1'b0;
    end else begin
      inflight <= ram_ren;
      if (state == IDLE && start) begin
        if (size_ok) begin
          err         <= 1'b0;
          size_x_r    <= size_x;
          pixels_r    <= frame_pixels;
          ram_address <= '0;
          flush_cnt   <= '0;
        end else begin
          err <= 1'b1;
        end
      end
      if (ram_ren)    ram_address <= ram_address + ADDR_WIDTH'(1);
      if (flush_push) flush_cnt   <= flush_cnt + 12'd1;
    end
  end

  // RAM data and a flush entry can land on the same edge; RAM data goes first.
  always_comb begin
    fifo0_next = fifo0;
    fifo1_next = fifo1;
    count_next = count;
    if (pop) begin
      fifo0_next = fifo1;
      count_next = count - 2'd1;
    end
    if (inflight) begin
      if (count_next == 2'd0) fifo0_next = {ram_data_out, 2'b00};
      else                    fifo1_next = {ram_data_out, 2'b00};
      count_next = count_next + 2'd1;
    end
    if (flush_push) begin
      if (count_next == 2'd0) fifo0_next = {{PIX_WIDTH{1'b0}}, 1'b1, last_flush};
      else                    fifo1_next = {{PIX_WIDTH{1'b0}}, 1'b1, last_flush};
      count_next = count_next + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo0 <= '0;
      fifo1 <= '0;
      count <= '0;
    end else begin
      fifo0 <= fifo0_next;
      fifo1 <= fifo1_next;
      count <= count_next;
    end
  end

  assign pixel_out_valid = count != 2'd0;
  assign pixel_out       = pixel_out_valid ? fifo0[EW-1:2] : '0;
  assign pixel_flush     = pixel_out_valid & fifo0[1];
  assign frame_end       = pixel_out_valid & fifo0[0];

endmodule

// File: tb/tb_pixel_streamer.sv
// Self-checking bench for pixel_streamer: behavioural RAM, expected-stream
// queue built from the frame rules, and one compare step per cycle.
module tb_pixel_streamer;

  localparam int PW    = 8;
  localparam int AW    = 13;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, pixel_out_ready = 1'b0;
  logic [11:0]   size_x = '0, size_y = '0;
  logic [AW-1:0] ram_address;
  logic          ram_ren, pixel_out_valid, pixel_flush, frame_end, busy, err;
  logic [PW-1:0] ram_data_out, pixel_out;
  logic [PW-1:0] mem [DEPTH];

  int total = 0, bad = 0;

  logic [PW+1:0] exp_q[$];
  logic [PW+1:0] got_q[$];
  bit            m_busy, m_err, held;
  logic [PW+1:0] held_val;
  int            m_pixels, reads_issued, data_xfers, xfers, last_ren_addr;
  int            cyc = 0, start_cyc = 0, first_valid_cyc = -1;
  int            ready_mode = 0, pat_idx = 0;

  pixel_streamer #(.PIX_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .size_x(size_x), .size_y(size_y),
    .ram_address(ram_address), .ram_ren(ram_ren), .ram_data_out(ram_data_out),
    .pixel_out(pixel_out), .pixel_out_valid(pixel_out_valid),
    .pixel_out_ready(pixel_out_ready), .pixel_flush(pixel_flush),
    .frame_end(frame_end), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_ren) ram_data_out <= mem[ram_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    m_busy = 0; m_err = 0; held = 0;
    reads_issued = 0; data_xfers = 0; xfers = 0; m_pixels = 0;
  endtask

  // One compare step per cycle, then model update for transfers and start.
  task automatic check_output();
    logic [PW+1:0] head, e;
    bit busy_before;
    int sx, sy, n;
    head = {pixel_out, pixel_flush, frame_end};
    busy_before = m_busy;
    cyc++;
    check("busy", busy, m_busy);
    check("err", err, m_err);
    if (ram_ren) begin
      check("ren_in_frame", busy_before && (reads_issued < m_pixels), 1);
      check("ren_addr", ram_address, reads_issued);
      check("ren_slot", (reads_issued - data_xfers) < 2, 1);
      last_ren_addr = ram_address;
      reads_issued++;
    end
    if (held) check("hold_valid", pixel_out_valid, 1);
    if (pixel_out_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc - start_cyc;
      if (held) check("hold_stable", head, held_val);
      if (exp_q.size() == 0) check("extra_pixel", pixel_out_valid, 0);
      else                   check("pixel", head, exp_q[0]);
      if (pixel_out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got_q.push_back(head);
        xfers++;
        if (!e[1]) data_xfers++;
        if (e[0]) m_busy = 0;
      end
      held = !pixel_out_ready;
      held_val = head;
    end else begin
      held = 0;
    end
    if (start && !busy_before) begin
      sx = int'(size_x); sy = int'(size_y); n = sx * sy;
      if (sx != 0 && sy != 0 && n <= DEPTH) begin
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back({mem[i], 2'b00});
        for (int j = 0; j <= sx; j++) exp_q.push_back({{PW{1'b0}}, 1'b1, (j == sx)});
        m_busy = 1; m_err = 0; m_pixels = n;
        reads_issued = 0; data_xfers = 0; xfers = 0;
        start_cyc = cyc; first_valid_cyc = -1;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic apply_stimulus(input bit st, input int sx, input int sy);
    @(posedge clk); #1;
    start  = st;
    size_x = 12'(sx);
    size_y = 12'(sy);
    case (ready_mode)
      0:       pixel_out_ready = 1'b1;
      1:       pixel_out_ready = (pat_idx % 3) == 0;
      default: pixel_out_ready = ($urandom_range(0, 3) != 0);
    endcase
    pat_idx++;
    @(negedge clk);
    check_output();
  endtask

  task automatic run_frame(input int sx, input int sy, input int limit);
    int n = 0;
    while (m_busy && n < limit) begin
      apply_stimulus(0, sx, sy);
      n++;
    end
    check("frame_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) mem[i] = PW'(i);
    reset_model();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", pixel_out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_ren", ram_ren, 0);
    check("reset_addr", ram_address, 0);

    // Basic 4x3 frame, ready held high.
    ready_mode = 0;
    apply_stimulus(1, 4, 3);
    run_frame(4, 3, 200);
    check("basic_first_valid", first_valid_cyc, 3);
    check("basic_len", got_q.size(), 17);
    check("basic_px0", got_q[0], {8'd0, 2'b00});
    check("basic_px11", got_q[11], {8'd11, 2'b00});
    check("basic_flush0", got_q[12], {8'd0, 2'b10});
    check("basic_end", got_q[16], {8'd0, 2'b11});
    apply_stimulus(0, 4, 3);
    check("basic_busy_after", busy, 0);

    // Same frame with ready pattern 1,0,0.
    ready_mode = 1; pat_idx = 0;
    apply_stimulus(1, 4, 3);
    run_frame(4, 3, 400);
    check("bp_len", got_q.size(), 17);
    check("bp_px5", got_q[5], {8'd5, 2'b00});

    // Invalid sizes, then a valid 2x2 start clears err.
    ready_mode = 0;
    apply_stimulus(1, 0, 5);
    apply_stimulus(0, 0, 5);
    check("err_zero_x", err, 1);
    apply_stimulus(1, 128, 65);
    apply_stimulus(0, 128, 65);
    check("err_oversize", err, 1);
    check("busy_oversize", busy, 0);
    apply_stimulus(1, 2, 2);
    run_frame(2, 2, 200);
    check("err_cleared", err, 0);
    check("small_len", got_q.size(), 7);

    // Start ignored mid-frame; size change after accepted start.
    apply_stimulus(1, 4, 3);
    apply_stimulus(0, 9, 9);
    apply_stimulus(0, 9, 9);
    apply_stimulus(1, 3, 1);
    run_frame(9, 9, 400);
    check("ignore_len", got_q.size(), 17);

    // Random frames, random contents, random backpressure, back-to-back starts.
    ready_mode = 2;
    for (int f = 0; f < 6; f++) begin
      int sx, sy;
      for (int i = 0; i < 512; i++) mem[i] = PW'($urandom);
      sx = $urandom_range(1, 16);
      sy = $urandom_range(1, 16);
      apply_stimulus(1, sx, sy);
      run_frame(sx, sy, 4000);
      check("rand_len", got_q.size(), sx * sy + sx + 1);
    end

    // Largest frame: every address read once, 8191 last.
    for (int i = 0; i < DEPTH; i++) mem[i] = PW'($urandom);
    apply_stimulus(1, 128, 64);
    run_frame(128, 64, 40000);
    check("max_reads", reads_issued, 8192);
    check("max_last_addr", last_ren_addr, 8191);
    check("max_len", got_q.size(), 8192 + 129);

    // Asynchronous reset after five transfers, then restream.
    for (int i = 0; i < 16; i++) mem[i] = PW'(i);
    ready_mode = 0;
    apply_stimulus(1, 4, 3);
    n = 0;
    while (xfers < 5 && n < 100) begin
      apply_stimulus(0, 4, 3);
      n++;
    end
    check("rst_setup_xfers", xfers, 5);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_pixel", pixel_out, 0);
    check("rst_valid", pixel_out_valid, 0);
    check("rst_flush", pixel_flush, 0);
    check("rst_end", frame_end, 0);
    check("rst_busy", busy, 0);
    check("rst_ren", ram_ren, 0);
    check("rst_addr", ram_address, 0);
    repeat (2) begin
      @(negedge clk);
      check("rst_no_reads", ram_ren, 0);
    end
    reset_model();
    @(posedge clk); #1 rst = 1'b0;
    apply_stimulus(1, 4, 3);
    run_frame(4, 3, 200);
    check("restart_len", got_q.size(), 17);
    check("restart_px0", got_q[0], {8'd0, 2'b00});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
